// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared constants, next-PC source encoding and fetch helpers
package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
    localparam logic [31:0] IMEM_BASE_DEF  = 32'h0000_3000;
    localparam int          IMEM_WORDS_DEF = 4096;
    localparam logic [31:0] NOP            = 32'h0000_0000;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] FUNC_JR    = 6'h08;
    localparam logic [5:0] FUNC_JALR  = 6'h09;

    // Which rule decided the next PC; the top also uses it to steer IF/ID.
    typedef enum logic [2:0] {
        SRC_FLUSH,
        SRC_HOLD,
        SRC_JUMP,
        SRC_BRANCH,
        SRC_SEQ
    } npc_src_e;

    // PC-relative branch target of the instruction in D (delay-slot relative).
    function automatic logic [31:0] branch_target(input logic [31:0] pc, input logic [15:0] imm);
        return pc + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
    endfunction

    // Fault when misaligned or outside [base, limit); compared in 33 bits so
    // a window ending at 2^32 still works.
    function automatic logic fetch_fault(input logic [31:0] pc, input logic [31:0] base,
                                         input logic [32:0] limit);
        return (pc[1:0] != 2'b00) || ({1'b0, pc} < {1'b0, base}) || ({1'b0, pc} >= limit);
    endfunction

    // Control-transfer classification matching the branch/jump unit's decode.
    function automatic logic is_redirect_op(input logic [31:0] instr);
        return (instr[31:26] == OP_J) || (instr[31:26] == OP_JAL) ||
               (instr[31:26] == OP_BEQ) || (instr[31:26] == OP_BNE) ||
               ((instr[31:26] == OP_SPECIAL) &&
                ((instr[5:0] == FUNC_JR) || (instr[5:0] == FUNC_JALR)));
    endfunction

endpackage

// File: rtl/fetch_unit_npc_sel.sv
// fetch_unit_npc_sel: prioritised next-PC selection (flush > stall > jump > branch > seq)
module fetch_unit_npc_sel
    import fetch_unit_pkg::*;
(
    input  logic [31:0] f_pc,
    input  logic [31:0] d_pc,
    input  logic [15:0] d_imm,
    input  logic        flush,
    input  logic        stall,
    input  logic        d_branch,
    input  logic        d_jump,
    input  logic [31:0] flush_pc,
    input  logic [31:0] d_jump_addr,
    output logic [31:0] next_pc,
    output npc_src_e    src
);

    // Stall ignores redirects since D operands are not final yet.
    always_comb begin
        src     = SRC_SEQ;
        next_pc = f_pc + 32'd4;
        if (flush) begin
            src     = SRC_FLUSH;
            next_pc = flush_pc;
        end else if (stall) begin
            src     = SRC_HOLD;
            next_pc = f_pc;
        end else if (d_jump) begin
            src     = SRC_JUMP;
            next_pc = d_jump_addr;
        end else if (d_branch) begin
            src     = SRC_BRANCH;
            next_pc = branch_target(d_pc, d_imm);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, next-PC selection and IF/ID register of the MIPS pipeline
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] IMEM_BASE  = IMEM_BASE_DEF,
    parameter int          IMEM_WORDS = IMEM_WORDS_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        d_branch,
    input  logic        d_jump,
    input  logic [31:0] d_jump_addr,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] f_pc,
    output logic [31:0] d_instr,
    output logic [31:0] d_pc,
    output logic [31:0] d_pc8,
    output logic        d_valid,
    output logic        d_fetch_err
);

    localparam logic [32:0] IMEM_LIMIT = {1'b0, IMEM_BASE} + (33'(IMEM_WORDS) << 2);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] dpc_q, dpc_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [31:0] next_pc;
    npc_src_e    src;
    logic        fault;

    fetch_unit_npc_sel u_npc_sel (
        .f_pc        (pc_q),
        .d_pc        (dpc_q),
        .d_imm       (instr_q[15:0]),
        .flush       (flush),
        .stall       (stall),
        .d_branch    (d_branch),
        .d_jump      (d_jump),
        .flush_pc    (flush_pc),
        .d_jump_addr (d_jump_addr),
        .next_pc     (next_pc),
        .src         (src)
    );

    // Fault detection on the current fetch address and IF/ID next-state.
    always_comb begin
        fault   = fetch_fault(pc_q, IMEM_BASE, IMEM_LIMIT);
        pc_d    = next_pc;
        instr_d = fault ? NOP : imem_rdata;
        dpc_d   = pc_q;
        valid_d = 1'b1;
        err_d   = fault;
        if (src == SRC_FLUSH) begin
            instr_d = NOP;
            dpc_d   = 32'd0;
            valid_d = 1'b0;
            err_d   = 1'b0;
        end else if (src == SRC_HOLD) begin
            instr_d = instr_q;
            dpc_d   = dpc_q;
            valid_d = valid_q;
            err_d   = err_q;
        end
    end

    // PC and IF/ID state; reset drops any redirect in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP;
            dpc_q   <= 32'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            dpc_q   <= dpc_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign imem_addr   = pc_q;
    assign f_pc        = pc_q;
    assign d_instr     = instr_q;
    assign d_pc        = dpc_q;
    assign d_pc8       = dpc_q + 32'd8;
    assign d_valid     = valid_q;
    assign d_fetch_err = err_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC register, next-PC selection and the IF/ID pipeline register.
- Consumes branch/jump decisions produced combinationally in D by the branch/jump unit.
- Presents the instruction-memory address and hands the decoded-stage instruction and PC downstream.
- MIPS architectural delay slot: a redirect in D affects the fetch after the one already in flight.

Parameters:
RESET_PC, 32'h0000_3000, PC value after reset
IMEM_BASE, 32'h0000_3000, first byte address of instruction memory
IMEM_WORDS, 4096, instruction memory depth in words

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
stall  in  1  hazard-unit stall; freezes PC and IF/ID
flush  in  1  kill IF/ID contents and redirect PC to flush_pc
flush_pc  in  32  redirect target used when flush=1
d_branch  in  1  branch condition true for instruction in D
d_jump  in  1  instruction in D is j/jal/jr/jalr
d_jump_addr  in  32  absolute jump target from branch/jump unit
imem_addr  out  32  fetch address (= f_pc)
imem_rdata  in  32  instruction word at imem_addr, same cycle (combinational ROM)
f_pc  out  32  current PC register value
d_instr  out  32  IF/ID instruction
d_pc  out  32  IF/ID PC
d_pc8  out  32  d_pc + 8 (link value)
d_valid  out  1  IF/ID holds a real fetched instruction
d_fetch_err  out  1  IF/ID instruction came from a faulting fetch

Behaviour:
- Reset: asynchronous, active-high. While asserted: f_pc=RESET_PC, d_instr=0, d_pc=0, d_valid=0, d_fetch_err=0. First rising edge after release performs a normal fetch.
- Fetch fault (combinational on f_pc): f_pc[1:0]!=0, f_pc<IMEM_BASE, or f_pc>=IMEM_BASE+4*IMEM_WORDS. On a fault the IF/ID load captures instr=0 (nop), d_fetch_err=1, d_valid=1, d_pc=f_pc.
- Branch target: d_pc + 4 + {{14{d_instr[15]}}, d_instr[15:0], 2'b00}, modulo 2^32.
- Next PC, evaluated each edge, priority high to low:
  - flush: f_pc <= flush_pc; IF/ID <= bubble (instr 0, valid 0, err 0, pc 0). Dominates stall and redirects.
  - stall: f_pc and all IF/ID fields hold. d_branch and d_jump are ignored because D operands are not final.
  - d_jump: f_pc <= d_jump_addr, used verbatim with no alignment fix-up. Misalignment surfaces as a fetch fault next cycle.
  - d_branch: f_pc <= branch target.
  - otherwise: f_pc <= f_pc + 4. 32'hFFFF_FFFC wraps to 0; the resulting out-of-range address faults.
- d_jump and d_branch both 1 cannot occur legally; jump wins.
- IF/ID when neither flush nor stall: d_instr <= imem_rdata (or 0 on fault), d_pc <= f_pc, d_valid <= 1. The delay-slot instruction at f_pc therefore enters D on the same edge the redirect loads f_pc.
- d_branch/d_jump are qualified only by the D-stage instruction. When d_valid=0 the fetch unit still obeys them; the branch/jump unit decodes nop as neither.
- d_pc8 is combinational from d_pc. imem_addr is combinational from f_pc. No other combinational input-to-output paths.
- Latency: one cycle from f_pc to IF/ID. The redirect takes effect on the edge at which the D instruction is present and stall=0.
- Reset asserted mid-stall or mid-redirect: reset wins immediately, with no pending redirect retained.

Decomposition:
- Shared constants header: RESET_PC/IMEM_BASE defaults, NOP word (32'h0), OP/FUNC codes already used by the branch/jump unit.
- One combinational sub-module, npc_sel: inputs f_pc, d_pc, d_instr[15:0], the control bits and d_jump_addr; output next_pc.
- The PC register and IF/ID register stay in fetch_unit.

Test Plan:
- Reset and sequential fetch: reset pulse mid-cycle, then 3 edges. Required: f_pc 0x3000 -> 0x3004 -> 0x3008 -> 0x300C, d_pc trails by one cycle, d_valid goes 0 -> 1 after the first edge, d_pc8 = d_pc + 8.
- Backward branch with delay slot: d_pc=0x3008, d_instr imm=0xFFFE, d_branch=1, f_pc=0x300C. Required after the edge: f_pc=0x3004, d_pc=0x300C.
- Stall blocks jump: stall=1 with d_jump=1, d_jump_addr=0x3100 for 2 cycles, then stall=0. Required: f_pc and d_* frozen for 2 cycles, f_pc=0x3100 on the first unstalled edge.
- Flush over stall and branch: flush=1, stall=1, d_branch=1, flush_pc=0x4180. Required: f_pc=0x4180, d_valid=0, d_instr=0.
- Fetch faults: jump to 0x3002, then to 0x2FFC, then to IMEM_BASE+0x4000. Required: each enters D with d_instr=0, d_fetch_err=1, d_valid=1 and d_pc equal to the faulting address.
- Async reset mid-operation: assert reset between edges during a stalled redirect. Required: outputs reach their reset values before the next edge, with no redirect afterwards.
